// File: rtl/prescaler_debouncer.sv
// Purpose: clock-enable prescaler plus per-channel pushbutton synchronizer/debouncer.
// Latency: CE every DIV enabled cycles; a clean button edge reaches BTN_DB in 2 cycles + STABLE ticks.
// Backpressure: none; free-running conditioning stage, EN low freezes the divider and thus debouncing.
module prescaler_debouncer #(
  parameter int DIV    = 50000,
  parameter int STABLE = 4,
  parameter int NBTN   = 3
) (
  input  logic            CLK,
  input  logic            CLR_N,
  input  logic            EN,
  input  logic [NBTN-1:0] BTN,
  output logic            CE,
  output logic [NBTN-1:0] BTN_DB,
  output logic [NBTN-1:0] BTN_RISE,
  output logic [NBTN-1:0] BTN_FALL
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (STABLE > 0) ? $clog2(STABLE + 1) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);
  localparam logic [SW-1:0] SC_LAST = SW'(STABLE - 1);

  // Two-stage synchronizer; bs_q is the metastability-safe button sample.
  logic [NBTN-1:0] sync1_q, sync1_d;
  logic [NBTN-1:0] bs_q, bs_d;

  // Prescaler count and its registered enable pulse.
  logic [PW-1:0] pc_q, pc_d;
  logic          ce_q, ce_d;

  // Debouncer state per channel.
  logic [NBTN-1:0][SW-1:0] sc_q, sc_d;
  logic [NBTN-1:0]         db_q, db_d;
  logic [NBTN-1:0]         rise_q, rise_d;
  logic [NBTN-1:0]         fall_q, fall_d;

  // Synchronizer shifts every cycle, independent of EN.
  always_comb begin
    sync1_d = BTN;
    bs_d    = sync1_q;
  end

  // Divider: wrap at DIV-1 and emit a one-cycle CE; hold the count while EN is low.
  always_comb begin
    pc_d = pc_q;
    ce_d = 1'b0;
    if (EN) begin
      if (pc_q == PC_LAST) begin
        pc_d = '0;
        ce_d = 1'b1;
      end else begin
        pc_d = pc_q + PW'(1);
      end
    end
  end

  // Debounce on the edge following a CE pulse; a matching sample discards progress.
  always_comb begin
    sc_d   = sc_q;
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    if (ce_q) begin
      for (int i = 0; i < NBTN; i++) begin
        if (bs_q[i] == db_q[i]) begin
          sc_d[i] = '0;
        end else if (sc_q[i] == SC_LAST) begin
          sc_d[i]   = '0;
          db_d[i]   = bs_q[i];
          rise_d[i] = bs_q[i];
          fall_d[i] = ~bs_q[i];
        end else begin
          sc_d[i] = sc_q[i] + SW'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      sync1_q <= '0;
      bs_q    <= '0;
      pc_q    <= '0;
      ce_q    <= 1'b0;
      sc_q    <= '0;
      db_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      bs_q    <= bs_d;
      pc_q    <= pc_d;
      ce_q    <= ce_d;
      sc_q    <= sc_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign CE       = ce_q;
  assign BTN_DB   = db_q;
  assign BTN_RISE = rise_q;
  assign BTN_FALL = fall_q;

endmodule
